gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively exercises a 4-input combinational gate block in hardware. It drives all 16 input vectors onto the gate's a/b/c/d inputs, waits a programmable settle time, and samples the gate's q output. Each sample is compared against a parameterised truth table, and a pass/fail summary is reported. It sits beside any `main`-style gate instance as an on-chip self-check, replacing the simulation-only sweep.

## Interface
- `EXPECTED`, 16'h6996: expected truth table; bit i = expected q for input vector i (default is 4-input XOR).
- `SETTLE`, 2: cycles the vector is held before the sample cycle; legal range 1..15.

- `clk`  in  1  rising-edge clock, single domain.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `a`  out  1  vector bit 3 (MSB) to gate.
- `b`  out  1  vector bit 2 to gate.
- `c`  out  1  vector bit 1 to gate.
- `d`  out  1  vector bit 0 (LSB) to gate.
- `q`  in  1  gate output under test.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  last sweep had zero mismatches; held until next start.
- `fail_count`  out  5  mismatches in last sweep, 0..16.
- `first_fail_idx`  out  4  lowest mismatching vector index; 0 when fail_count==0.
- `captured`  out  16  sampled q per vector; bit i = q for vector i.

## Operation
- FSM states: IDLE, WAIT, SAMPLE, DONE. Moore outputs decoded from registered state.
- IDLE: busy=0, {a,b,c,d}=4'b0000. If start=1, then: idx<=0, cnt<=SETTLE-1, fail_count<=0, first_fail_idx<=0, captured<=0, ->WAIT.
- WAIT: {a,b,c,d}=idx. If cnt==0 ->SAMPLE, else cnt<=cnt-1. WAIT lasts exactly SETTLE cycles.
- SAMPLE: {a,b,c,d}=idx, lasting one cycle. On exit edge:
  - captured[idx]<=q.
  - If q!=EXPECTED[idx]: fail_count<=fail_count+1; if this is the first mismatch, first_fail_idx<=idx.
  - If idx==15 ->DONE; else idx<=idx+1, cnt<=SETTLE-1, ->WAIT.
- DONE: done=1, busy=0, {a,b,c,d} held at 4'b1111. pass<=(final fail_count==0), registered on entry so it is valid in the DONE cycle. Unconditionally ->IDLE.
- busy=1 exactly in WAIT and SAMPLE.
- fail_count is 5 bits so 16 mismatches cannot wrap. idx wrap 15->0 never occurs; DONE is taken instead.
- start asserted in WAIT, SAMPLE or DONE is ignored (not queued). start held high continuously re-launches a sweep from the IDLE cycle after each DONE.
- Results (pass, fail_count, first_fail_idx, captured) hold their values in IDLE until the next accepted start clears them.
- rst (any time, including mid-sweep): state=IDLE, idx=0, cnt=0, a=b=c=d=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, captured=0. The next start restarts at vector 0.

## Timing
- Start accepted at edge E0. Vector k is driven from E0 and sampled on edge E0+(k+1)(SETTLE+1).
- With SETTLE=2: 3 cycles per vector, last sample at E0+48, done high during cycle E0+48..E0+49, busy falls at E0+48.
- Sweep length is 16*(SETTLE+1) cycles plus 1 DONE cycle plus at least 1 IDLE cycle before the next accept. Minimum start-to-start interval is 16*(SETTLE+1)+2 cycles.
- q is treated as combinational from a/b/c/d. The gate path must settle within SETTLE+1 cycles of a vector change.
- The vector changes only on the edge leaving SAMPLE, never inside WAIT.

## Test plan
- Ideal XOR gate, EXPECTED=16'h6996, SETTLE=2, start pulse -> busy for 48 cycles, done pulse at E0+48, captured=16'h6996, fail_count=0, pass=1, first_fail_idx=0.
- q tied 0, default EXPECTED -> captured=16'h0000, fail_count=8, first_fail_idx=1, pass=0.
- q = inverted XOR -> captured=16'h9669, fail_count=16 (no wrap), first_fail_idx=0, pass=0.
- Monitor a..d with SETTLE=5 -> each vector 0..15 is held exactly 6 cycles in ascending order, and q is sampled on the 6th edge.
- Assert rst while idx=7 -> all outputs 0 immediately (async, no clock edge needed); a fresh start then sweeps 0..15 and reproduces scenario 1 results.
- Pulse start in mid-sweep and during the done cycle -> both ignored; exactly one done pulse, and results are unchanged from a single sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// On-chip exhaustive sweep of a 4-input combinational gate: drives all 16 vectors,
// waits a programmable settle time, samples q and scores it against a truth table.
module gate_sweep_ctrl #(
  parameter logic [15:0] EXPECTED = 16'h6996,
  parameter int unsigned SETTLE   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        q,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [15:0] captured
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [4:0]  fail_count_r, fail_count_s;
  logic [3:0]  first_fail_idx_r, first_fail_idx_s;
  logic [15:0] captured_r, captured_s;
  logic        pass_r, pass_s;
  logic [3:0]  vec_r, vec_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        mismatch_s;

  assign mismatch_s = (q != EXPECTED[idx_r]);

  // Next-state and result update logic.
  always_comb begin
    state_s          = state_r;
    idx_s            = idx_r;
    cnt_s            = cnt_r;
    fail_count_s     = fail_count_r;
    first_fail_idx_s = first_fail_idx_r;
    captured_s       = captured_r;
    pass_s           = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s            = 4'd0;
          cnt_s            = CNT_LOAD;
          fail_count_s     = 5'd0;
          first_fail_idx_s = 4'd0;
          captured_s       = 16'd0;
          pass_s           = 1'b0;
          state_s          = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_SAMPLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_SAMPLE: begin
        captured_s[idx_r] = q;
        if (mismatch_s) begin
          fail_count_s = fail_count_r + 5'd1;
          // A zero running count means this is the first mismatch of the sweep.
          if (fail_count_r == 5'd0) begin
            first_fail_idx_s = idx_r;
          end else begin
            first_fail_idx_s = first_fail_idx_r;
          end
        end else begin
          fail_count_s = fail_count_r;
        end
        if (idx_r == 4'd15) begin
          pass_s  = (fail_count_s == 5'd0);
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_r + 4'd1;
          cnt_s   = CNT_LOAD;
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs are registered yet track state.
  always_comb begin
    vec_s  = 4'd0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_IDLE: begin
        vec_s = 4'd0;
      end
      ST_WAIT, ST_SAMPLE: begin
        vec_s  = idx_s;
        busy_s = 1'b1;
      end
      ST_DONE: begin
        vec_s  = 4'hF;
        done_s = 1'b1;
      end
      default: begin
        vec_s = 4'd0;
      end
    endcase
  end

  // State, result and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      idx_r            <= 4'd0;
      cnt_r            <= 4'd0;
      fail_count_r     <= 5'd0;
      first_fail_idx_r <= 4'd0;
      captured_r       <= 16'd0;
      pass_r           <= 1'b0;
      vec_r            <= 4'd0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      state_r          <= state_s;
      idx_r            <= idx_s;
      cnt_r            <= cnt_s;
      fail_count_r     <= fail_count_s;
      first_fail_idx_r <= first_fail_idx_s;
      captured_r       <= captured_s;
      pass_r           <= pass_s;
      vec_r            <= vec_s;
      busy_r           <= busy_s;
      done_r           <= done_s;
    end
  end

  assign a              = vec_r[3];
  assign b              = vec_r[2];
  assign c              = vec_r[1];
  assign d              = vec_r[0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign fail_count     = fail_count_r;
  assign first_fail_idx = first_fail_idx_r;
  assign captured       = captured_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: truth-table gate models with random tables, scored
// against popcount/lowest-bit reference results and cycle-exact timing.
module tb_gate_sweep_ctrl;

  localparam logic [15:0] EXP = 16'h6996;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, a0, b0, c0, d0, q0, busy0, done0, pass0;
  logic [4:0]  fc0;
  logic [3:0]  ffi0;
  logic [15:0] cap0, tt0;
  logic start1, a1, b1, c1, d1, q1, busy1, done1, pass1;
  logic [4:0]  fc1;
  logic [3:0]  ffi1;
  logic [15:0] cap1, tt1;

  int n_cmp = 0;
  int n_bad = 0;

  // The gates under test are arbitrary truth tables indexed by {a,b,c,d}.
  assign q0 = tt0[{a0, b0, c0, d0}];
  assign q1 = tt1[{a1, b1, c1, d1}];

  gate_sweep_ctrl #(.EXPECTED(EXP), .SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0), .d(d0), .q(q0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
    .first_fail_idx(ffi0), .captured(cap0));

  gate_sweep_ctrl #(.EXPECTED(EXP), .SETTLE(5)) u_s5 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1), .q(q1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_idx(ffi1), .captured(cap1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int popcount16(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int lowest16(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One SETTLE=2 sweep; poke re-pulses start mid-sweep and during DONE.
  task automatic sweep0(input logic [15:0] tt, input string tag, input bit poke);
    logic [15:0] diff;
    int n, busy_n, extra;
    diff   = tt ^ EXP;
    tt0    = tt;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    busy_n = 0;
    while (!done0 && n < 200) begin
      if (busy0) busy_n++;
      if (poke && n == 20) start0 = 1'b1;
      if (poke && n == 21) start0 = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_lat"}, n, 48);
    check({tag, "_busy_cycles"}, busy_n, 48);
    check({tag, "_busy_in_done"}, busy0, 0);
    check({tag, "_vec_done"}, {a0, b0, c0, d0}, 4'hF);
    check({tag, "_captured"}, cap0, tt);
    check({tag, "_fail_count"}, fc0, popcount16(diff));
    check({tag, "_first_fail"}, ffi0, lowest16(diff));
    check({tag, "_pass"}, pass0, (diff == 16'd0));
    if (poke) start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    check({tag, "_done_pulse"}, done0, 0);
    check({tag, "_idle_busy"}, busy0, 0);
    check({tag, "_idle_vec"}, {a0, b0, c0, d0}, 4'd0);
    check({tag, "_held_cap"}, cap0, tt);
    check({tag, "_held_pass"}, pass0, (diff == 16'd0));
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk); #1;
        if (done0 || busy0) extra++;
      end
      check({tag, "_no_relaunch"}, extra, 0);
      check({tag, "_held_fc"}, fc0, popcount16(diff));
    end
  endtask

  // One SETTLE=5 sweep with a run-length record of the driven vectors.
  task automatic sweep1(input logic [15:0] tt, input string tag);
    int vals[$];
    int lens[$];
    int n;
    logic [15:0] diff;
    diff   = tt ^ EXP;
    tt1    = tt;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 400) begin
      if (busy1) begin
        if (vals.size() > 0 && vals[vals.size()-1] == int'({a1, b1, c1, d1}))
          lens[lens.size()-1] = lens[lens.size()-1] + 1;
        else begin
          vals.push_back(int'({a1, b1, c1, d1}));
          lens.push_back(1);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_lat"}, n, 96);
    check({tag, "_runs"}, vals.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < vals.size()) begin
        check($sformatf("%s_vec%0d", tag, i), vals[i], i);
        check($sformatf("%s_hold%0d", tag, i), lens[i], 6);
      end
    end
    check({tag, "_captured"}, cap1, tt);
    check({tag, "_fail_count"}, fc1, popcount16(diff));
    check({tag, "_first_fail"}, ffi1, lowest16(diff));
    check({tag, "_pass"}, pass1, (diff == 16'd0));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tt0 = EXP;
    tt1 = EXP;
    #12;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_vec", {a0, b0, c0, d0}, 4'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy0, 0);
    check("idle_cap", cap0, 16'd0);

    sweep0(EXP, "xor", 1'b0);
    sweep0(16'h0000, "zero", 1'b0);
    sweep0(16'h9669, "inv", 1'b0);
    for (int k = 0; k < 3; k++) sweep0(16'($urandom), $sformatf("rnd%0d", k), 1'b0);

    sweep1(EXP, "s5");
    sweep1(16'($urandom), "s5rnd");

    // Asynchronous reset part-way through a sweep, at vector 7.
    tt0 = EXP;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while ({a0, b0, c0, d0} != 4'd7 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reach7", {a0, b0, c0, d0}, 4'd7);
    #2 rst = 1'b1;
    #1;
    check("arst_vec", {a0, b0, c0, d0}, 4'd0);
    check("arst_busy", busy0, 0);
    check("arst_done", done0, 0);
    check("arst_pass", pass0, 0);
    check("arst_fc", fc0, 0);
    check("arst_ffi", ffi0, 0);
    check("arst_cap", cap0, 16'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_idle", busy0, 0);
    sweep0(EXP, "post_rst", 1'b0);

    sweep0(16'h0000, "poke", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
